alu_result_sink: RTL and testbench
==================================

// Module: alu_result_sink
// PURPOSE
//  Receiving end of the ALU wrapper's typed output stream (data_out / data_type).
//  Accepts tagged 8-bit beats and assembles them into complete ALU records {A, B, OPCODE, RESULT, FLAGS}.
//  Checks tag ordering and queues finished records in a small FIFO for a downstream reader.
//  Sits between the ALU wrapper and any logger, bench scoreboard or host port.
// PARAMETERS
//  DEPTH  4  record FIFO depth, power of two, >=2
//  ERR_W  8  width of the saturating error counters
// PORTS
//  clk          in   1      system clock, rising edge
//  rst          in   1      asynchronous reset, ACTIVE-LOW (rst==0 resets)
//  in_valid     in   1      beat present on data_in/data_type
//  data_in      in   8      signed beat payload (wrapper data_out)
//  data_type    in   3      beat tag: 0 IDLE,1 OP_A,2 OP_B,3 OPCODE,4 RESULT,5 FLAGS,6-7 reserved
//  in_ready     out  1      sink can take a beat this cycle
//  rd_en        in   1      pop head record
//  rec_valid    out  1      FIFO non-empty; rec_* hold head record
//  rec_a        out  8      operand A
//  rec_b        out  8      operand B
//  rec_op       out  3      opcode (data_in[2:0] of OPCODE beat)
//  rec_res      out  8      result
//  rec_flags    out  4      {C,Z,N,V} (data_in[3:0] of FLAGS beat)
//  rec_mismatch out  1      head record failed the result check
//  err_cnt      out  ERR_W  tag-order errors, saturating
//  chk_cnt      out  ERR_W  result-check failures, saturating
// BEHAVIOUR
//  - Beat accepted on a rising edge with in_valid && in_ready. IDLE beats are accepted and ignored.
//  - in_ready = !(state==S_FLAGS && fifo_full). Combinational; does not depend on rd_en.
//  - FSM (expected tag): S_A(1) -> S_B(2) -> S_OP(3) -> S_RES(4) -> S_FLAGS(5) -> S_A.
//  - Wrong tag (including reserved 6/7): err_cnt+1, partial record discarded.
//    If that tag is OP_A, it is latched as the new A and state -> S_B; otherwise state -> S_A.
//  - FLAGS beat accepted at edge N: record pushed at edge N. rec_valid is high after N when the FIFO was empty.
//  - FIFO is first-word-fall-through: rec_* are valid whenever rec_valid=1, and rd_en pops at the edge.
//  - rd_en while empty is ignored. Simultaneous push and pop leaves the count unchanged.
//  - Pointers wrap modulo DEPTH. Overflow is impossible because of in_ready.
//  - Counters stick at 2^ERR_W-1.
//  - Reset (async, any state, mid-record): state S_A, FIFO emptied, storage zeroed, both counters 0.
//    Every rec_* output, rec_valid and rec_mismatch read 0; in_ready=1. Partial record lost.
// CONFIGURATION
//  ALU_RESULT_CHECK_EN defined:
//    On FLAGS accept, recompute the result from A, B and OPCODE.
//    Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 SHL A,1, 7 SHR A,1 (arithmetic); 8-bit wrap.
//    On mismatch with RESULT: store rec_mismatch=1 with the record and chk_cnt+1.
//  Undefined: no checker logic; rec_mismatch and chk_cnt tied to 0.
// STRUCTURE
//  alu_pkg: tag codes, opcode codes, FSM state encoding, record width (31b + mismatch).
//  Sub-module sync_fifo (WIDTH, DEPTH) is a generic FWFT FIFO with full/empty outputs.
//  Top level holds the FSM, the assembly registers, the counters and the optional checker.
// TESTING
//  1. Reset: rst=0 mid-record, release -> rec_valid=0, err_cnt=0, in_ready=1, state S_A.
//  2. Beats A=5,B=3,OP=0,RES=8,FLAGS=0 -> one record {5,3,0,8,0}, rec_valid after FLAGS edge, mismatch=0.
//  3. A=7 then OP_A=9 -> err_cnt=1. Then B=2,OP=1,RES=7,FLAGS=0 -> record A=9.
//  4. Fill DEPTH records with no reads -> in_ready=0 at S_FLAGS. Pop one -> FLAGS accepted; order preserved.
//  5. CHECK_EN: A=-128,B=-1,OP=1(SUB),RES=0x00 -> rec_mismatch=1, chk_cnt=1 (expected 0x81).
//  6. Reserved tag 6 in S_RES, then 300 further errors -> state S_A, err_cnt saturates at 255.

Source files
------------

// File: rtl/alu_result_sink_pkg.sv
// alu_result_sink_pkg: beat tags, opcodes, FSM encoding, record layout and reference ALU
package alu_result_sink_pkg;
  typedef enum logic [2:0] {
    T_IDLE  = 3'd0,
    T_A     = 3'd1,
    T_B     = 3'd2,
    T_OP    = 3'd3,
    T_RES   = 3'd4,
    T_FLAGS = 3'd5
  } tag_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } op_t;
  // each state is encoded as the tag it expects next
  typedef enum logic [2:0] {
    S_A     = 3'd1,
    S_B     = 3'd2,
    S_OP    = 3'd3,
    S_RES   = 3'd4,
    S_FLAGS = 3'd5
  } state_t;
  typedef struct packed {
    logic       mismatch;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] res;
    logic [3:0] flags;
  } rec_t;
  localparam int REC_W = $bits(rec_t);
  function automatic logic [7:0] alu_calc(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      OP_ADD:  alu_calc = a + b;
      OP_SUB:  alu_calc = a - b;
      OP_AND:  alu_calc = a & b;
      OP_OR:   alu_calc = a | b;
      OP_XOR:  alu_calc = a ^ b;
      OP_NOT:  alu_calc = ~a;
      OP_SHL:  alu_calc = {a[6:0], 1'b0};
      default: alu_calc = {a[7], a[7:1]};
    endcase
  endfunction
endpackage

// File: rtl/alu_result_sink_sync_fifo.sv
// sync_fifo: generic first-word-fall-through FIFO, async active-low reset clears storage
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign full  = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign rdata = mem[rp];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= wdata;
        wp      <= wp + 1'b1;
      end
      if (rd) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end
endmodule

// File: rtl/alu_result_sink.sv
// alu_result_sink: assembles tagged ALU beats into records and queues them; ALU_RESULT_CHECK_EN adds a result checker
module alu_result_sink
  import alu_result_sink_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       data_in,
  input  logic [2:0]       data_type,
  output logic             in_ready,
  input  logic             rd_en,
  output logic             rec_valid,
  output logic [7:0]       rec_a,
  output logic [7:0]       rec_b,
  output logic [2:0]       rec_op,
  output logic [7:0]       rec_res,
  output logic [3:0]       rec_flags,
  output logic             rec_mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] chk_cnt
);
  state_t state, state_nx;
  logic [7:0] a_r, b_r, res_r;
  logic [2:0] op_r;
  logic [ERR_W-1:0] err_q, chk_q;
  logic acc, hit, bad, push, mism, full, empty;
  rec_t wrec, hrec;
  assign in_ready = !(state == S_FLAGS && full);
  assign acc      = in_valid && in_ready && data_type != T_IDLE;
  assign hit      = data_type == state;
  assign bad      = acc && !hit;
  assign push     = acc && hit && state == S_FLAGS;
  assign wrec     = {mism, a_r, b_r, op_r, res_r, data_in[3:0]};
  always_comb begin
    state_nx = state;
    if (acc) state_nx = hit ? (state == S_FLAGS ? S_A : state_t'(state + 3'd1)) : (data_type == T_A ? S_B : S_A);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_A;
    else state <= state_nx;
  end
  // every field register tracks the latest beat of its tag; only an in-order sequence reaches the push
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r   <= '0;
      b_r   <= '0;
      op_r  <= '0;
      res_r <= '0;
      err_q <= '0;
    end else begin
      if (acc && data_type == T_A) a_r <= data_in;
      if (acc && data_type == T_B) b_r <= data_in;
      if (acc && data_type == T_OP) op_r <= data_in[2:0];
      if (acc && data_type == T_RES) res_r <= data_in;
      if (bad && err_q != '1) err_q <= err_q + 1'b1;
    end
  end
`ifdef ALU_RESULT_CHECK_EN
  assign mism = alu_calc(a_r, b_r, op_r) != res_r;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chk_q <= '0;
    else if (push && mism && chk_q != '1) chk_q <= chk_q + 1'b1;
  end
`else
  assign mism  = 1'b0;
  assign chk_q = '0;
`endif
  sync_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wrec),
    .pop   (rd_en),
    .rdata (hrec),
    .full  (full),
    .empty (empty)
  );
  assign rec_valid    = !empty;
  assign rec_a        = hrec.a;
  assign rec_b        = hrec.b;
  assign rec_op       = hrec.op;
  assign rec_res      = hrec.res;
  assign rec_flags    = hrec.flags;
  assign rec_mismatch = hrec.mismatch;
  assign err_cnt      = err_q;
  assign chk_cnt      = chk_q;
endmodule

// File: tb/tb_alu_result_sink.sv
// tb_alu_result_sink: directed and random beats checked against a queue-based record model
module tb_alu_result_sink;
  localparam int DEPTH = 4;
  localparam int ERR_W = 8;
  localparam int SAT = (1 << ERR_W) - 1;
  logic clk = 0, rst = 1;
  logic in_valid = 0, rd_en = 0;
  logic [7:0] data_in = 0;
  logic [2:0] data_type = 0;
  logic in_ready, rec_valid, rec_mismatch;
  logic [7:0] rec_a, rec_b, rec_res;
  logic [2:0] rec_op;
  logic [3:0] rec_flags;
  logic [ERR_W-1:0] err_cnt, chk_cnt;
  always #5 clk = ~clk;
  alu_result_sink #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .data_type(data_type),
    .in_ready(in_ready), .rd_en(rd_en), .rec_valid(rec_valid), .rec_a(rec_a), .rec_b(rec_b),
    .rec_op(rec_op), .rec_res(rec_res), .rec_flags(rec_flags), .rec_mismatch(rec_mismatch),
    .err_cnt(err_cnt), .chk_cnt(chk_cnt)
  );
  typedef struct {
    logic [7:0] a, b, res;
    logic [2:0] op;
    logic [3:0] fl;
    logic       mm;
  } mrec_t;
  mrec_t q[$];
  logic [7:0] fld [5];
  int pos, m_err, m_chk, vectors, fails;
  function automatic logic [7:0] ref_res(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return 8'hFF - a;
      3'd6: return a * 2;
      default: return (a >> 1) | (a & 8'h80);
    endcase
  endfunction
  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", nm, obs, exp);
    end
  endtask
  task automatic check_outputs();
    chk("in_ready", in_ready, (pos == 4 && q.size() == DEPTH) ? 0 : 1);
    chk("rec_valid", rec_valid, q.size() > 0);
    chk("err_cnt", err_cnt, m_err);
    chk("chk_cnt", chk_cnt, m_chk);
    if (q.size() > 0) begin
      chk("rec_a", rec_a, q[0].a);
      chk("rec_b", rec_b, q[0].b);
      chk("rec_op", rec_op, q[0].op);
      chk("rec_res", rec_res, q[0].res);
      chk("rec_flags", rec_flags, q[0].fl);
      chk("rec_mismatch", rec_mismatch, q[0].mm);
    end
  endtask
  task automatic step(input logic v, input logic [2:0] tag, input logic [7:0] d, input logic rd);
    mrec_t r;
    logic ready;
    @(negedge clk);
    check_outputs();
    in_valid = v; data_type = tag; data_in = d; rd_en = rd;
    vectors++;
    ready = !(pos == 4 && q.size() == DEPTH);
    if (rd && q.size() > 0) void'(q.pop_front());
    if (v && ready && tag != 0) begin
      if (int'(tag) == pos + 1) begin
        fld[pos] = d;
        pos++;
        if (pos == 5) begin
          r.a = fld[0]; r.b = fld[1]; r.op = fld[2][2:0]; r.res = fld[3]; r.fl = fld[4][3:0];
`ifdef ALU_RESULT_CHECK_EN
          r.mm = ref_res(r.a, r.b, r.op) != r.res;
`else
          r.mm = 0;
`endif
          if (r.mm && m_chk < SAT) m_chk++;
          q.push_back(r);
          pos = 0;
        end
      end else begin
        if (m_err < SAT) m_err++;
        if (tag == 3'd1) begin
          fld[0] = d;
          pos = 1;
        end else pos = 0;
      end
    end
  endtask
  task automatic send_rec(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic [7:0] res, input logic [3:0] fl);
    step(1, 3'd1, a, 0);
    step(1, 3'd2, b, 0);
    step(1, 3'd3, {5'd0, op}, 0);
    step(1, 3'd4, res, 0);
    step(1, 3'd5, {4'd0, fl}, 0);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #2;
    in_valid = 0; rd_en = 0; data_type = 0;
    rst = 0;
    q.delete(); pos = 0; m_err = 0; m_chk = 0;
    @(negedge clk);
    chk("rst_rec_valid", rec_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_chk_cnt", chk_cnt, 0);
    chk("rst_fields", {rec_a, rec_b, rec_op, rec_res, rec_flags, rec_mismatch}, 0);
    @(negedge clk);
    rst = 1;
  endtask
  initial begin
    do_reset();
    send_rec(8'd5, 8'd3, 3'd0, 8'd8, 4'd0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(1, 3'd1, 8'd7, 0);
    step(1, 3'd1, 8'd9, 0);
    step(1, 3'd2, 8'd2, 0);
    step(1, 3'd3, 8'd1, 0);
    step(1, 3'd4, 8'd7, 0);
    step(1, 3'd5, 8'd0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(1, 3'd1, 8'd11, 0);
    step(1, 3'd2, 8'd12, 0);
    do_reset();
    step(1, 3'd3, 8'd2, 0);
    for (int k = 0; k < DEPTH; k++)
      send_rec(8'($urandom), 8'($urandom), 3'($urandom), 8'($urandom), 4'($urandom));
    step(1, 3'd1, 8'h21, 0);
    step(1, 3'd2, 8'h22, 0);
    step(1, 3'd3, 8'h04, 0);
    step(1, 3'd4, 8'h23, 0);
    for (int k = 0; k < 3; k++) step(1, 3'd5, 8'h0A, 0);
    step(1, 3'd5, 8'h0A, 1);
    step(1, 3'd5, 8'h0A, 0);
    for (int k = 0; k < DEPTH + 2; k++) step(0, 0, 0, 1);
    send_rec(8'h80, 8'hFF, 3'd1, 8'h00, 4'd0);
    step(0, 0, 0, 0);
    send_rec(8'h80, 8'hFF, 3'd1, 8'h81, 4'd3);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 3'd1, 8'd1, 0);
    step(1, 3'd2, 8'd2, 0);
    step(1, 3'd3, 8'd3, 0);
    step(1, 3'd6, 8'd4, 0);
    for (int k = 0; k < 300; k++) step(1, 3'd7, 8'($urandom), 0);
    step(0, 0, 0, 0);
    chk("err_saturated", err_cnt, SAT);
    do_reset();
    for (int k = 0; k < 600; k++)
      step($urandom_range(9) != 0,
           ($urandom_range(99) < 85) ? 3'(pos + 1) : 3'($urandom_range(7)),
           8'($urandom), $urandom_range(9) < 3);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
